// File: rtl/uart_pkg.sv
// Shared UART receive types, constants and small bit-level helper functions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_e;

    localparam int   UART_MAX_BITS = 8;
    localparam logic PAR_EVEN      = 1'b0;
    localparam logic PAR_ODD       = 1'b1;

    // Frame lengths outside 1..8 fall back to a full byte.
    function automatic logic [3:0] eff_len(input logic [3:0] len);
        if (len == 4'd0 || len > 4'(UART_MAX_BITS))
            return 4'(UART_MAX_BITS);
        else
            return len;
    endfunction

    function automatic logic parity_expect(input logic acc, input logic ptype);
        case (ptype)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            default:  return acc;
        endcase
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchronizer and mid-bit sample picker; UART_RX_MAJORITY_EN selects a 2-of-3
// vote over ticks mid-1..mid+1 (decided at mid+1) instead of a single mid sample.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    input  logic          rx_tick,
    input  logic [CW-1:0] tick_cnt,
    output logic          rxs,
    output logic          sample,
    output logic          sample_valid
);
    import uart_pkg::*;

    logic [1:0] sync_r;

    // Two-flop synchronizer, reset to the idle-high line level
    always_ff @(posedge clk) begin
        if (reset)
            sync_r <= 2'b11;
        else
            sync_r <= {sync_r[0], rx};
    end

    assign rxs = sync_r[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_r;

    // History of rxs at the two previous ticks for the vote
    always_ff @(posedge clk) begin
        if (reset)
            hist_r <= 2'b11;
        else if (rx_tick)
            hist_r <= {hist_r[0], rxs};
        else
            hist_r <= hist_r;
    end

    assign sample       = maj3(hist_r[1], hist_r[0], rxs);
    assign sample_valid = rx_tick && (tick_cnt == CW'(OVERSAMPLE / 2));
`else
    assign sample       = rxs;
    assign sample_valid = rx_tick && (tick_cnt == CW'(OVERSAMPLE / 2 - 1));
`endif

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start/data/parity/stop recovery from an oversampled line.
// Optional majority sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_tick,
    input  logic       rx,
    input  logic [3:0] frame_length,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       stop2,
    output logic [7:0] rx_dout,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err
);
    import uart_pkg::*;

    localparam int            CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] TICK_MAX = CW'(OVERSAMPLE - 1);

    uart_rx_state_e state_r;
    logic [CW-1:0]  tick_cnt_r;
    logic [3:0]     bit_cnt_r;
    logic [3:0]     len_r;
    logic           par_en_r;
    logic           par_type_r;
    logic           stop2_r;
    logic           stop_cnt_r;
    logic [7:0]     shreg_r;
    logic           par_acc_r;
    logic           par_bad_r;
    logic           fe_acc_r;
    logic           armed_r;
    logic [7:0]     rx_dout_r;
    logic           rx_done_r;
    logic           parity_err_r;
    logic           frame_err_r;

    logic rxs_s;
    logic sample_s;
    logic sample_valid_s;
    logic stop_fe_s;

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .CW(CW)) u_sampler (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rx_tick      (rx_tick),
        .tick_cnt     (tick_cnt_r),
        .rxs          (rxs_s),
        .sample       (sample_s),
        .sample_valid (sample_valid_s)
    );

    assign stop_fe_s = fe_acc_r | ~sample_s;

    // Receive FSM, bit-phase counters, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            tick_cnt_r   <= {CW{1'b0}};
            bit_cnt_r    <= 4'd0;
            len_r        <= 4'd0;
            par_en_r     <= 1'b0;
            par_type_r   <= 1'b0;
            stop2_r      <= 1'b0;
            stop_cnt_r   <= 1'b0;
            shreg_r      <= 8'h00;
            par_acc_r    <= 1'b0;
            par_bad_r    <= 1'b0;
            fe_acc_r     <= 1'b0;
            armed_r      <= 1'b0;
            rx_dout_r    <= 8'h00;
            rx_done_r    <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            rx_done_r <= 1'b0;
            if (rx_tick) begin
                // Phase counter is held at zero while idle so the start edge sets bit phase
                if (state_r == IDLE || tick_cnt_r == TICK_MAX)
                    tick_cnt_r <= {CW{1'b0}};
                else
                    tick_cnt_r <= tick_cnt_r + CW'(1);

                case (state_r)
                    IDLE: begin
                        if (rxs_s)
                            armed_r <= 1'b1;
                        else if (armed_r)
                            state_r <= START;
                    end
                    START: begin
                        if (sample_valid_s) begin
                            if (!sample_s) begin
                                state_r    <= DATA;
                                len_r      <= eff_len(frame_length);
                                par_en_r   <= parity_en;
                                par_type_r <= parity_type;
                                stop2_r    <= stop2;
                                bit_cnt_r  <= 4'd0;
                                stop_cnt_r <= 1'b0;
                                shreg_r    <= 8'h00;
                                par_acc_r  <= 1'b0;
                                par_bad_r  <= 1'b0;
                                fe_acc_r   <= 1'b0;
                            end else begin
                                state_r <= IDLE;
                            end
                        end
                    end
                    DATA: begin
                        if (sample_valid_s) begin
                            shreg_r   <= {sample_s, shreg_r[7:1]};
                            par_acc_r <= par_acc_r ^ sample_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == len_r - 4'd1)
                                state_r <= par_en_r ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        if (sample_valid_s) begin
                            par_bad_r <= (sample_s != parity_expect(par_acc_r, par_type_r));
                            state_r   <= STOP;
                        end
                    end
                    STOP: begin
                        if (sample_valid_s) begin
                            if (stop2_r && !stop_cnt_r) begin
                                stop_cnt_r <= 1'b1;
                                fe_acc_r   <= stop_fe_s;
                            end else begin
                                rx_dout_r    <= shreg_r >> (4'd8 - len_r);
                                parity_err_r <= par_en_r & par_bad_r;
                                frame_err_r  <= stop_fe_s;
                                rx_done_r    <= 1'b1;
                                state_r      <= IDLE;
                                // A low line at a framing error is a break: wait for idle before re-arming
                                if (stop_fe_s && !rxs_s)
                                    armed_r <= 1'b0;
                            end
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign rx_dout    = rx_dout_r;
    assign rx_done    = rx_done_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;

endmodule
